// File: rtl/fft_2_butterfly.sv
// ---------------------------------------------------------------------------
// fft_2_butterfly
//
// Radix-2 decimation-in-time butterfly for single-precision complex data:
//   y1 = x1 + W*x2,   y2 = x1 - W*x2,   W = exp(-j*2*pi*r/256)
//
// The block has no arithmetic of its own. It sequences two external float
// adders and two external float multipliers, each with a fixed latency of
// LAT cycles, through five rounds:
//   MUL0 : P1 = r2*c,  P2 = i2*s
//   MUL1 : Q1 = i2*c,  Q2 = r2*s
//   ADDT : tr = P1 + P2,  ti = Q1 - Q2       (W*x2 = tr + j*ti)
//   ADDR : newr1 = r1 + tr,  newr2 = r1 - tr
//   ADDI : newi1 = i1 + ti,  newi2 = i1 - ti
// Each round presents registered operands for LAT+1 cycles and captures the
// unit results on the edge that ends its last cycle.
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   r1, i1, r2, i2      butterfly inputs x1 and x2 (IEEE-754 single)
//   r                   twiddle index 0..127
//   start / ready       one-cycle request, accepted only while ready is high
//   valid               newr1/newi1/newr2/newi2 hold a completed result
//   newr1..newi2        results y1 and y2
//   a1, b1, a2, b2      adder operands (sum = a + b)
//   sum1, sum2          adder results
//   m1, n1, m2, n2      multiplier operands (prod = m * n)
//   prod1, prod2        multiplier results
// ---------------------------------------------------------------------------
module fft_2_butterfly #(
  parameter int LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] r1,
  input  logic [31:0] i1,
  input  logic [31:0] r2,
  input  logic [31:0] i2,
  input  logic [6:0]  r,
  input  logic        start,
  output logic        ready,
  output logic        valid,
  output logic [31:0] newr1,
  output logic [31:0] newi1,
  output logic [31:0] newr2,
  output logic [31:0] newi2,
  output logic [31:0] a1,
  output logic [31:0] b1,
  output logic [31:0] a2,
  output logic [31:0] b2,
  input  logic [31:0] sum1,
  input  logic [31:0] sum2,
  output logic [31:0] m1,
  output logic [31:0] n1,
  output logic [31:0] m2,
  output logic [31:0] n2,
  input  logic [31:0] prod1,
  input  logic [31:0] prod2
);

  // -------------------------------------------------------------------------
  // Twiddle ROM
  // -------------------------------------------------------------------------
  // Only a quarter wave, cos(j*pi/128) for j = 0..64, is generated; the
  // 128-entry cos/sin tables are folded out of it. Building sin from the
  // mirrored cos entries makes entry 0 exactly (1.0, 0.0) and entry 64
  // exactly (0.0, 1.0) instead of inheriting rounding residue of pi/2.
  localparam real PI_R = 3.14159265358979323846;

  // Constant function: cos(j*pi/128) rounded to the nearest single-precision
  // bit pattern. A Taylor series is used so that elaboration relies only on
  // plain real arithmetic. Every value lies in (0, 1], so only normal
  // positive encodings are produced.
  function automatic logic [31:0] quarter_cos(input int j);
    real    x;
    real    term;
    real    sum;
    real    a;
    int     e;
    longint m;
    if (j >= 64) begin
      return 32'h0000_0000;
    end
    if (j == 0) begin
      return 32'h3F80_0000;
    end
    x    = PI_R * real'(j) / 128.0;
    term = 1.0;
    sum  = 1.0;
    for (int n = 1; n <= 20; n++) begin
      term = -term * x * x / real'((2 * n - 1) * (2 * n));
      sum  = sum + term;
    end
    // Normalise into [1, 2) and round the 23-bit fraction to nearest.
    a = sum;
    e = 0;
    for (int k = 0; k < 64; k++) begin
      if (a < 1.0) begin
        a = a * 2.0;
        e = e - 1;
      end
    end
    m = longint'(a * 8388608.0);
    if (m >= 64'sd16777216) begin
      m = 64'sd8388608;
      e = e + 1;
    end
    return {1'b0, 8'(e + 127), m[22:0]};
  endfunction

  logic [31:0] quarter [0:64];
  logic [31:0] cos_tab [0:127];
  logic [31:0] sin_tab [0:127];

  genvar gi;
  generate
    for (gi = 0; gi <= 64; gi++) begin : g_quarter
      localparam logic [31:0] QV = quarter_cos(gi);
      assign quarter[gi] = QV;
    end

    for (gi = 0; gi < 128; gi++) begin : g_twiddle
      if (gi <= 64) begin : g_first_quadrant
        assign cos_tab[gi] = quarter[gi];
        assign sin_tab[gi] = quarter[64 - gi];
      end else begin : g_second_quadrant
        // cos is negative past pi/2; sin(t) = cos(t - pi/2).
        assign cos_tab[gi] = {~quarter[128 - gi][31], quarter[128 - gi][30:0]};
        assign sin_tab[gi] = quarter[gi - 64];
      end
    end
  endgenerate

  logic [31:0] tw_c;
  logic [31:0] tw_s;
  assign tw_c = cos_tab[r];
  assign tw_s = sin_tab[r];

  // Float negation used to turn the external adders into subtractors.
  function automatic logic [31:0] fneg(input logic [31:0] v);
    return {~v[31], v[30:0]};
  endfunction

  // -------------------------------------------------------------------------
  // Sequencer state
  // -------------------------------------------------------------------------
  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL0,
    S_MUL1,
    S_ADDT,
    S_ADDR,
    S_ADDI,
    S_DONE
  } state_t;

  localparam int CW = (LAT < 1) ? 1 : $clog2(LAT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(LAT);

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        ready_q, ready_d;
  logic        valid_q, valid_d;

  // Operands latched at start, so later input changes cannot disturb a run.
  logic [31:0] xr1_q, xr1_d;
  logic [31:0] xi1_q, xi1_d;
  logic [31:0] xr2_q, xr2_d;
  logic [31:0] xi2_q, xi2_d;
  logic [31:0] c_q, c_d;
  logic [31:0] s_q, s_d;

  // Intermediate products/sums still needed by a later round. Q1/Q2 are
  // consumed on the same edge they are captured, so they need no storage.
  logic [31:0] p1_q, p1_d;
  logic [31:0] p2_q, p2_d;
  logic [31:0] ti_q, ti_d;

  logic [31:0] a1_q, a1_d;
  logic [31:0] b1_q, b1_d;
  logic [31:0] a2_q, a2_d;
  logic [31:0] b2_q, b2_d;
  logic [31:0] m1_q, m1_d;
  logic [31:0] n1_q, n1_d;
  logic [31:0] m2_q, m2_d;
  logic [31:0] n2_q, n2_d;

  logic [31:0] newr1_q, newr1_d;
  logic [31:0] newi1_q, newi1_d;
  logic [31:0] newr2_q, newr2_d;
  logic [31:0] newi2_q, newi2_d;

  logic last_cycle;
  assign last_cycle = (cnt_q == CNT_LAST);

  // -------------------------------------------------------------------------
  // Next-state logic. Operands for a round are computed on the edge that
  // enters it, so they are already registered during the round's first
  // cycle. Results captured on a round's final edge can therefore feed the
  // next round's operands directly from sum/prod.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    valid_d = valid_q;
    xr1_d   = xr1_q;
    xi1_d   = xi1_q;
    xr2_d   = xr2_q;
    xi2_d   = xi2_q;
    c_d     = c_q;
    s_d     = s_q;
    p1_d    = p1_q;
    p2_d    = p2_q;
    ti_d    = ti_q;
    a1_d    = a1_q;
    b1_d    = b1_q;
    a2_d    = a2_q;
    b2_d    = b2_q;
    m1_d    = m1_q;
    n1_d    = n1_q;
    m2_d    = m2_q;
    n2_d    = n2_q;
    newr1_d = newr1_q;
    newi1_d = newi1_q;
    newr2_d = newr2_q;
    newi2_d = newi2_q;

    // Round counter: advance inside a round, wrap when the round ends.
    if (state_q != S_IDLE && state_q != S_DONE) begin
      cnt_d = last_cycle ? '0 : cnt_q + CW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          xr1_d   = r1;
          xi1_d   = i1;
          xr2_d   = r2;
          xi2_d   = i2;
          c_d     = tw_c;
          s_d     = tw_s;
          ready_d = 1'b0;
          valid_d = 1'b0;
          cnt_d   = '0;
          m1_d    = r2;
          n1_d    = tw_c;
          m2_d    = i2;
          n2_d    = tw_s;
          state_d = S_MUL0;
        end
      end

      S_MUL0: begin
        if (last_cycle) begin
          p1_d    = prod1;
          p2_d    = prod2;
          m1_d    = xi2_q;
          n1_d    = c_q;
          m2_d    = xr2_q;
          n2_d    = s_q;
          state_d = S_MUL1;
        end
      end

      S_MUL1: begin
        if (last_cycle) begin
          m1_d    = '0;
          n1_d    = '0;
          m2_d    = '0;
          n2_d    = '0;
          a1_d    = p1_q;
          b1_d    = p2_q;
          a2_d    = prod1;
          b2_d    = fneg(prod2);
          state_d = S_ADDT;
        end
      end

      S_ADDT: begin
        if (last_cycle) begin
          // sum1 is tr; it goes straight into the real-part round.
          ti_d    = sum2;
          a1_d    = xr1_q;
          b1_d    = sum1;
          a2_d    = xr1_q;
          b2_d    = fneg(sum1);
          state_d = S_ADDR;
        end
      end

      S_ADDR: begin
        if (last_cycle) begin
          newr1_d = sum1;
          newr2_d = sum2;
          a1_d    = xi1_q;
          b1_d    = ti_q;
          a2_d    = xi1_q;
          b2_d    = fneg(ti_q);
          state_d = S_ADDI;
        end
      end

      S_ADDI: begin
        if (last_cycle) begin
          newi1_d = sum1;
          newi2_d = sum2;
          a1_d    = '0;
          b1_d    = '0;
          a2_d    = '0;
          b2_d    = '0;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        valid_d = 1'b1;
        ready_d = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers. Reset wins over everything, including a start in the
  // same cycle, and aborts a butterfly in progress.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      xr1_q   <= '0;
      xi1_q   <= '0;
      xr2_q   <= '0;
      xi2_q   <= '0;
      c_q     <= '0;
      s_q     <= '0;
      p1_q    <= '0;
      p2_q    <= '0;
      ti_q    <= '0;
      a1_q    <= '0;
      b1_q    <= '0;
      a2_q    <= '0;
      b2_q    <= '0;
      m1_q    <= '0;
      n1_q    <= '0;
      m2_q    <= '0;
      n2_q    <= '0;
      newr1_q <= '0;
      newi1_q <= '0;
      newr2_q <= '0;
      newi2_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      xr1_q   <= xr1_d;
      xi1_q   <= xi1_d;
      xr2_q   <= xr2_d;
      xi2_q   <= xi2_d;
      c_q     <= c_d;
      s_q     <= s_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      ti_q    <= ti_d;
      a1_q    <= a1_d;
      b1_q    <= b1_d;
      a2_q    <= a2_d;
      b2_q    <= b2_d;
      m1_q    <= m1_d;
      n1_q    <= n1_d;
      m2_q    <= m2_d;
      n2_q    <= n2_d;
      newr1_q <= newr1_d;
      newi1_q <= newi1_d;
      newr2_q <= newr2_d;
      newi2_q <= newi2_d;
    end
  end

  assign ready = ready_q;
  assign valid = valid_q;
  assign newr1 = newr1_q;
  assign newi1 = newi1_q;
  assign newr2 = newr2_q;
  assign newi2 = newi2_q;
  assign a1    = a1_q;
  assign b1    = b1_q;
  assign a2    = a2_q;
  assign b2    = b2_q;
  assign m1    = m1_q;
  assign n1    = n1_q;
  assign m2    = m2_q;
  assign n2    = n2_q;

endmodule

// File: tb/tb_fft_2_butterfly.sv
// ---------------------------------------------------------------------------
// tb_fft_2_butterfly
//
// Directed bench for fft_2_butterfly. The external adders and multipliers
// are modelled as two-stage pipelined single-precision units (latency 2).
// Each task drives one scenario and checks against hand-computed values.
// ---------------------------------------------------------------------------
module tb_fft_2_butterfly;

  logic        clk;
  logic        rst;
  logic [31:0] r1, i1, r2, i2;
  logic [6:0]  r;
  logic        start;
  logic        ready, valid;
  logic [31:0] newr1, newi1, newr2, newi2;
  logic [31:0] a1, b1, a2, b2, sum1, sum2;
  logic [31:0] m1, n1, m2, n2, prod1, prod2;

  int n_vec  = 0;
  int n_fail = 0;

  fft_2_butterfly #(.LAT(2)) dut (
    .clk   (clk),
    .rst   (rst),
    .r1    (r1),
    .i1    (i1),
    .r2    (r2),
    .i2    (i2),
    .r     (r),
    .start (start),
    .ready (ready),
    .valid (valid),
    .newr1 (newr1),
    .newi1 (newi1),
    .newr2 (newr2),
    .newi2 (newi2),
    .a1    (a1),
    .b1    (b1),
    .a2    (a2),
    .b2    (b2),
    .sum1  (sum1),
    .sum2  (sum2),
    .m1    (m1),
    .n1    (n1),
    .m2    (m2),
    .n2    (n2),
    .prod1 (prod1),
    .prod2 (prod2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- float unit model ----------------
  function automatic real f2r(input logic [31:0] b);
    real v;
    int  e;
    if (b[30:23] == 8'd0) return 0.0;
    v = 1.0 + real'(b[22:0]) / 8388608.0;
    e = int'(b[30:23]) - 127;
    for (int k = 0; k < 200; k++) begin
      if (e > 0) begin v = v * 2.0; e = e - 1; end
      else if (e < 0) begin v = v / 2.0; e = e + 1; end
    end
    return b[31] ? -v : v;
  endfunction

  function automatic logic [31:0] r2f(input real v);
    logic   s;
    real    a;
    int     e;
    longint m;
    if (v == 0.0) return 32'h0;
    s = (v < 0.0);
    a = s ? -v : v;
    e = 0;
    for (int k = 0; k < 200; k++) begin
      if (a >= 2.0) begin a = a / 2.0; e = e + 1; end
      else if (a < 1.0) begin a = a * 2.0; e = e - 1; end
    end
    m = longint'(a * 8388608.0);
    if (m >= 64'sd16777216) begin m = 64'sd8388608; e = e + 1; end
    return {s, 8'(e + 127), m[22:0]};
  endfunction

  logic [31:0] add1_s1 = 0, add1_s2 = 0, add2_s1 = 0, add2_s2 = 0;
  logic [31:0] mul1_s1 = 0, mul1_s2 = 0, mul2_s1 = 0, mul2_s2 = 0;

  always @(posedge clk) begin
    add1_s1 <= r2f(f2r(a1) + f2r(b1));
    add2_s1 <= r2f(f2r(a2) + f2r(b2));
    mul1_s1 <= r2f(f2r(m1) * f2r(n1));
    mul2_s1 <= r2f(f2r(m2) * f2r(n2));
    add1_s2 <= add1_s1;
    add2_s2 <= add2_s1;
    mul1_s2 <= mul1_s1;
    mul2_s2 <= mul2_s1;
  end

  assign sum1  = add1_s2;
  assign sum2  = add2_s2;
  assign prod1 = mul1_s2;
  assign prod2 = mul2_s2;

  // ---------------- stimulus helpers ----------------
  // Pulses start for one edge, then scrambles the data inputs.
  task automatic start_bfly(input logic [6:0] rr, input logic [31:0] xr1,
                            input logic [31:0] xi1, input logic [31:0] xr2,
                            input logic [31:0] xi2);
    @(negedge clk);
    r = rr; r1 = xr1; i1 = xi1; r2 = xr2; i2 = xi2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    r1 = 32'hDEADBEEF; i1 = 32'h12345678; r2 = 32'hCAFEF00D; i2 = 32'h0BADF00D;
    r = 7'h55;
  endtask

  // Cycles after the start edge until valid (-1 on timeout).
  task automatic wait_valid(output int cyc, output int ready_early);
    cyc = -1;
    ready_early = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (valid) begin
        cyc = i;
        break;
      end
      if (ready) ready_early++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", ready); end
    n_vec++;
    if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", valid); end
    n_vec++;
    if ((a1 | b1 | a2 | b2 | m1 | n1 | m2 | n2 | newr1 | newi1 | newr2 | newi2) !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outputs got or-reduce %h want 00000000",
               a1 | b1 | a2 | b2 | m1 | n1 | m2 | n2 | newr1 | newi1 | newr2 | newi2);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if (ready !== 1'b1) begin n_fail++; $display("FAIL idle_ready got %b want 1", ready); end
    $display("test_reset done");
  endtask

  task automatic test_r0;
    int cyc;
    int ready_early;
    start_bfly(7'd0, 32'h3F800000, 32'h0, 32'h40000000, 32'h0);
    cyc = -1;
    ready_early = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin
        n_vec++;
        if ({m1, n1, m2, n2} !== {32'h40000000, 32'h3F800000, 32'h0, 32'h0}) begin
          n_fail++;
          $display("FAIL r0_mul0_operands got %h %h %h %h want 40000000 3f800000 0 0", m1, n1, m2, n2);
        end
      end
      if (i == 11) begin
        n_vec++;
        if ({newr1, newr2} !== 64'h0) begin
          n_fail++;
          $display("FAIL r0_newr_early got %h %h want 0 0", newr1, newr2);
        end
      end
      if (i == 12) begin
        n_vec++;
        if ({newr1, newr2} !== {32'h40400000, 32'hBF800000}) begin
          n_fail++;
          $display("FAIL r0_newr_at_addr got %h %h want 40400000 bf800000", newr1, newr2);
        end
      end
      if (valid) begin cyc = i; break; end
      if (ready) ready_early++;
    end
    n_vec++;
    if (cyc !== 16) begin n_fail++; $display("FAIL r0_latency got %0d want 16", cyc); end
    n_vec++;
    if (ready !== 1'b1 || ready_early !== 0) begin
      n_fail++;
      $display("FAIL r0_ready got %b early=%0d want 1 early=0", ready, ready_early);
    end
    n_vec++;
    if ({newr1, newr2} !== {32'h40400000, 32'hBF800000}) begin
      n_fail++;
      $display("FAIL r0_real got %h %h want 40400000 bf800000", newr1, newr2);
    end
    n_vec++;
    if ({newi1[30:0], newi2[30:0]} !== 62'h0) begin
      n_fail++;
      $display("FAIL r0_imag got %h %h want +/-0", newi1, newi2);
    end
    n_vec++;
    if ((a1 | b1 | a2 | b2 | m1 | n1 | m2 | n2) !== 32'h0) begin
      n_fail++;
      $display("FAIL r0_idle_operands got %h %h %h %h %h %h %h %h want 0", a1, b1, a2, b2, m1, n1, m2, n2);
    end
    $display("test_r0 latency=%0d y1=(%h,%h) y2=(%h,%h)", cyc, newr1, newi1, newr2, newi2);
  endtask

  task automatic test_r64;
    int cyc;
    int re;
    start_bfly(7'd64, 32'h0, 32'h0, 32'h3F800000, 32'h0);
    wait_valid(cyc, re);
    n_vec++;
    if (cyc !== 16) begin n_fail++; $display("FAIL r64_latency got %0d want 16", cyc); end
    n_vec++;
    if ({newi1, newi2} !== {32'hBF800000, 32'h3F800000}) begin
      n_fail++;
      $display("FAIL r64_imag got %h %h want bf800000 3f800000", newi1, newi2);
    end
    n_vec++;
    if ({newr1[30:0], newr2[30:0]} !== 62'h0) begin
      n_fail++;
      $display("FAIL r64_real got %h %h want +/-0", newr1, newr2);
    end
    $display("test_r64 y1=(%h,%h) y2=(%h,%h)", newr1, newi1, newr2, newi2);

    // Full complex case: x1 = 1+j, x2 = 2+3j, W = -j -> y1 = 4-j, y2 = -2+3j
    start_bfly(7'd64, 32'h3F800000, 32'h3F800000, 32'h40000000, 32'h40400000);
    wait_valid(cyc, re);
    n_vec++;
    if ({newr1, newi1, newr2, newi2} !== {32'h40800000, 32'hBF800000, 32'hC0000000, 32'h40400000}) begin
      n_fail++;
      $display("FAIL r64_complex got %h %h %h %h want 40800000 bf800000 c0000000 40400000",
               newr1, newi1, newr2, newi2);
    end
    $display("test_r64_complex y1=(%h,%h) y2=(%h,%h)", newr1, newi1, newr2, newi2);
  endtask

  task automatic test_r32_r96;
    int cyc;
    int re;
    logic [31:0] dr, di;
    // r=32: W = (1-j)/sqrt2, x2 = 1 -> y1 = x1 + W
    start_bfly(7'd32, 32'h0, 32'h0, 32'h3F800000, 32'h0);
    wait_valid(cyc, re);
    dr = newr1 - 32'h3F3504F3;
    di = newi1 - 32'hBF3504F3;
    n_vec++;
    if (!(dr == 32'h0 || dr == 32'h1 || dr == 32'hFFFFFFFF)) begin
      n_fail++;
      $display("FAIL r32_real got %h want 3f3504f3 +/-1ulp", newr1);
    end
    n_vec++;
    if (!(di == 32'h0 || di == 32'h1 || di == 32'hFFFFFFFF)) begin
      n_fail++;
      $display("FAIL r32_imag got %h want bf3504f3 +/-1ulp", newi1);
    end
    $display("test_r32 y1=(%h,%h)", newr1, newi1);
    // r=96: W = -(1+j)/sqrt2 -> y1 = (-0.7071, -0.7071)
    start_bfly(7'd96, 32'h0, 32'h0, 32'h3F800000, 32'h0);
    wait_valid(cyc, re);
    dr = newr1 - 32'hBF3504F3;
    di = newi1 - 32'hBF3504F3;
    n_vec++;
    if (!(dr == 32'h0 || dr == 32'h1 || dr == 32'hFFFFFFFF) ||
        !(di == 32'h0 || di == 32'h1 || di == 32'hFFFFFFFF)) begin
      n_fail++;
      $display("FAIL r96_y1 got %h %h want bf3504f3 bf3504f3 +/-1ulp", newr1, newi1);
    end
    $display("test_r96 y1=(%h,%h)", newr1, newi1);
  endtask

  task automatic test_busy_start;
    int cyc;
    int ready_early;
    start_bfly(7'd0, 32'h40800000, 32'h0, 32'h3F800000, 32'h0);
    cyc = -1;
    ready_early = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (valid) begin cyc = i; break; end
      if (ready) ready_early++;
      @(negedge clk);
      start = (i == 4);
      if (i == 4) begin
        r = 7'd64; r1 = 32'h41200000; i1 = 32'h41200000; r2 = 32'h40000000; i2 = 32'h40000000;
      end
    end
    start = 1'b0;
    n_vec++;
    if (cyc !== 16) begin n_fail++; $display("FAIL busy_latency got %0d want 16", cyc); end
    n_vec++;
    if (ready_early !== 0) begin n_fail++; $display("FAIL busy_ready_early got %0d want 0", ready_early); end
    n_vec++;
    if ({newr1, newr2} !== {32'h40A00000, 32'h40400000}) begin
      n_fail++;
      $display("FAIL busy_result got %h %h want 40a00000 40400000", newr1, newr2);
    end
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (valid !== 1'b1 || ready !== 1'b1 || newr1 !== 32'h40A00000) begin
      n_fail++;
      $display("FAIL busy_hold got valid=%b ready=%b newr1=%h want 1 1 40a00000", valid, ready, newr1);
    end
    $display("test_busy_start latency=%0d y1r=%h y2r=%h", cyc, newr1, newr2);
  endtask

  task automatic test_reset_mid;
    int cyc;
    int re;
    start_bfly(7'd0, 32'h3F800000, 32'h40000000, 32'h40000000, 32'h40400000);
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (ready !== 1'b1 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_flags got ready=%b valid=%b want 1 0", ready, valid);
    end
    n_vec++;
    if ((a1 | b1 | a2 | b2 | m1 | n1 | m2 | n2 | newr1 | newi1 | newr2 | newi2) !== 32'h0) begin
      n_fail++;
      $display("FAIL midrst_outputs got %h %h %h %h %h %h %h %h want 0", a1, b1, a2, b2, m1, n1, m2, n2);
    end
    @(negedge clk);
    rst = 1'b0;
    // x1 = 1+2j, x2 = 2+3j, W = 1 -> y1 = 3+5j, y2 = -1-j
    start_bfly(7'd0, 32'h3F800000, 32'h40000000, 32'h40000000, 32'h40400000);
    wait_valid(cyc, re);
    n_vec++;
    if (cyc !== 16) begin n_fail++; $display("FAIL midrst_restart_latency got %0d want 16", cyc); end
    n_vec++;
    if ({newr1, newi1, newr2, newi2} !== {32'h40400000, 32'h40A00000, 32'hBF800000, 32'hBF800000}) begin
      n_fail++;
      $display("FAIL midrst_restart got %h %h %h %h want 40400000 40a00000 bf800000 bf800000",
               newr1, newi1, newr2, newi2);
    end
    $display("test_reset_mid y1=(%h,%h) y2=(%h,%h)", newr1, newi1, newr2, newi2);
  endtask

  task automatic test_rst_with_start;
    @(negedge clk);
    rst = 1'b1; start = 1'b1; r = 7'd0;
    r1 = 32'h3F800000; i1 = 32'h0; r2 = 32'h40000000; i2 = 32'h0;
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if (ready !== 1'b1 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rststart_flags got ready=%b valid=%b want 1 0", ready, valid);
    end
    n_vec++;
    if ({m1, n1} !== 64'h0) begin
      n_fail++;
      $display("FAIL rststart_operands got %h %h want 0 0", m1, n1);
    end
    $display("test_rst_with_start ready=%b", ready);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; r = 7'd0;
    r1 = 32'h0; i1 = 32'h0; r2 = 32'h0; i2 = 32'h0;
    test_reset();
    test_r0();
    test_r64();
    test_r32_r96();
    test_busy_start();
    test_reset_mid();
    test_rst_with_start();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_2_butterfly.md
FFT_2_BUTTERFLY -- requirements
Module: fft_2

Interface
REQ-001 Parameter LAT, default 2, fixed latency in clock cycles of the external float adders/multipliers driven by this block.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 r1, i1  input  32  real/imag of butterfly input x1, IEEE-754 single.
REQ-005 r2, i2  input  32  real/imag of butterfly input x2, IEEE-754 single.
REQ-006 r  input  7  twiddle index, W = exp(-j*2*pi*r/256), r = 0..127.
REQ-007 start  input  1  one-cycle request to begin a butterfly.
REQ-008 ready  output  1  high when idle and able to accept start.
REQ-009 valid  output  1  high when newr1/newi1/newr2/newi2 hold a completed result.
REQ-010 newr1, newi1, newr2, newi2  output  32  results y1 = x1 + W*x2 and y2 = x1 - W*x2, float.
REQ-011 a1, b1, a2, b2  output  32  operands of external adders 1 and 2 (sum = a + b).
REQ-012 sum1, sum2  input  32  external adder results.
REQ-013 m1, n1, m2, n2  output  32  operands of external multipliers 1 and 2 (prod = m * n).
REQ-014 prod1, prod2  input  32  external multiplier results.

Function
REQ-015 Internal 128-entry twiddle ROM SHALL hold c = cos(2*pi*k/256) and s = sin(2*pi*k/256) as float bit patterns; entry 0 exactly (1.0, 0.0), entry 64 exactly (0.0, 1.0).
REQ-016 On start while ready = 1, the block SHALL latch r1, i1, r2, i2 and the ROM entry for r, clear valid and ready, and enter MUL0; start while busy SHALL be ignored.
REQ-017 Subtraction SHALL be done by driving the b operand with its bit 31 inverted.
REQ-018 States and rounds: IDLE; MUL0 (m1=r2, n1=c, m2=i2, n2=s -> P1, P2); MUL1 (m1=i2, n1=c, m2=r2, n2=s -> Q1, Q2); ADDT (a1=P1, b1=P2, a2=Q1, b2=-Q2 -> tr, ti); ADDR (a1=r1, b1=tr, a2=r1, b2=-tr -> newr1, newr2); ADDI (a1=i1, b1=ti, a2=i1, b2=-ti -> newi1, newi2); DONE -> IDLE.
REQ-019 Each round SHALL drive its operands registered in its first cycle, hold them stable LAT+1 cycles, and capture sum/prod at the end of its last cycle; rounds run back to back.
REQ-020 With LAT = 2, valid and ready SHALL both rise exactly 16 cycles after the edge that sampled start; the four result outputs change only at ADDR/ADDI capture.
REQ-021 valid and the result outputs SHALL hold until the next accepted start or reset.
REQ-022 In IDLE, all adder/multiplier operand outputs SHALL be driven to 0.
REQ-023 r1, i1, r2, i2 and r changing after the start edge SHALL not affect the running operation.

Reset
REQ-024 rst high SHALL, at the next edge, force IDLE, ready = 1, valid = 0, all 32-bit outputs = 0, regardless of current state (reset mid-butterfly aborts it).
REQ-025 start asserted in the same cycle as rst SHALL be ignored.

Verification
REQ-026 Bench SHALL model adders/multipliers as single-precision float units with LAT = 2.
REQ-027 r=0, x1=(3F800000, 0), x2=(40000000, 0) -> newr1=40400000, newr2=BF800000, newi1=newi2=+/-0; valid at cycle 16.
REQ-028 r=64, x1=(0,0), x2=(3F800000, 0) -> y1=(+/-0, BF800000), y2=(+/-0, 3F800000).
REQ-029 r=32, x1=(0,0), x2=(3F800000, 0) -> newr1 ~ 3F3504F3, newi1 ~ BF3504F3 (within 1 ulp).
REQ-030 start pulsed again at cycle 5 of a butterfly -> ignored; first result unchanged, ready stays 0 until cycle 16.
REQ-031 rst at cycle 8 of a butterfly -> next cycle ready=1, valid=0, all outputs 0; a new start then completes normally.
